divider_sweeper: RTL
====================

DIVIDER_SWEEPER -- requirements
Module: divider_sweeper

Interface
REQ-001 Parameter: WIDTH, default 8, operand and result width in bits.
REQ-002 Parameter: TIMEOUT, default 64, maximum number of cycles a divider may stay busy per operation.
REQ-003 Parameter: ERR_W, default 16, width of the error counter.
REQ-004 clk  in  1  single clock; all logic is on its rising edge.
REQ-005 rst  in  1  reset; asynchronous, active-low.
REQ-006 go  in  1  one-cycle pulse; starts a sweep when idle.
REQ-007 abort  in  1  level; ends the sweep in progress.
REQ-008 stop_on_err  in  1  level; 1 halts the sweep at the first mismatch.
REQ-009 strt  out  1  start pulse, driven to both dividers.
REQ-010 dividend, divisor  out  WIDTH each  operands, driven to both dividers.
REQ-011 quotient_a, remainder_a, quotient_b, remainder_b  in  WIDTH each  results from dividers A and B.
REQ-012 not_valid_a, idle_a, not_valid_b, idle_b  in  1 each  status from dividers A and B.
REQ-013 busy  out  1  sweep in progress.
REQ-014 done  out  1  sweep finished; held until the next go.
REQ-015 pass  out  1  valid with done: no errors.
REQ-016 err_cnt  out  ERR_W  mismatch plus timeout count; saturates at all-ones.
REQ-017 timeout_flag  out  1  at least one timeout has occurred.
REQ-018 fail_dividend, fail_divisor  out  WIDTH each  operands of the first failure.

Function
REQ-019 FSM states: IDLE, LAUNCH, SETTLE, WAIT, CHECK, NEXT, FINISH.
REQ-020 IDLE: on go, clear err_cnt, timeout_flag, fail_* and done; set dividend = divisor = 0; go to LAUNCH.
REQ-021 go while busy=1 has no effect.
REQ-022 LAUNCH: strt = 1 for exactly one cycle; go to SETTLE.
REQ-023 SETTLE: one-cycle wait so the dividers can drop idle; go to WAIT.
REQ-024 WAIT: stay until idle_a & idle_b = 1, then go to CHECK.
REQ-025 WAIT timeout: a cycle counter runs in WAIT; after TIMEOUT cycles, count one error, set timeout_flag, and go to CHECK without comparing.
REQ-026 CHECK mismatch: any of quotient, remainder or not_valid differs between A and B.
REQ-027 CHECK contract violation: divisor = 0 with not_valid_a = 0 or not_valid_b = 0.
REQ-028 A mismatch or contract violation counts one error.
REQ-029 When both dividers report not_valid=1, quotient and remainder are don't-care and are not compared.
REQ-030 A second error in the same operation (e.g. timeout plus contract violation) does not increment err_cnt again.
REQ-031 fail_dividend and fail_divisor capture only the first error of the sweep.
REQ-032 NEXT: increment divisor; on divisor wrap, increment dividend; go to LAUNCH.
REQ-033 Sweep order: the full 2^(2*WIDTH) space, divisor in the inner loop.
REQ-034 After the operation {all-ones, all-ones}, go to FINISH instead of incrementing.
REQ-035 stop_on_err = 1 with an error in CHECK: go to FINISH; operands stay at the failing pair.
REQ-036 FINISH: done = 1, pass = (err_cnt == 0), busy = 0; return to IDLE.
REQ-037 busy = 1 in every state except IDLE and FINISH.
REQ-038 Abort: abort = 1 in any busy state goes to FINISH next cycle, pass forced to 0, strt = 0.
REQ-039 Abort during LAUNCH: the strt pulse already issued is not repeated.
REQ-040 err_cnt saturates at the all-ones value and never wraps.

Reset
REQ-041 Assertion of rst forces IDLE at once, independent of clk.
REQ-042 While rst is asserted, all outputs are 0: strt, busy, done, pass, err_cnt, timeout_flag, fail_* and operands.
REQ-043 Reset asserted mid-sweep loses all progress; the next sweep needs a new go after deassertion.

Structure
REQ-044 The FSM state encoding and default parameter constants live in the shared package divider_pkg.
REQ-045 The operand pair counter (increment, wrap, last-pair detect) is one sub-module, sweep_counter, parametrised by WIDTH.
REQ-046 The comparison and the timeout counter stay in the top module.

Verification
REQ-047 WIDTH=4, two correct dividers, go -> 256 operations, done=1, pass=1, err_cnt=0, timeout_flag=0.
REQ-048 WIDTH=4, B quotient forced wrong only at 9/2, stop_on_err=0 -> err_cnt=1, fail_dividend=9, fail_divisor=2, pass=0, sweep runs to 15/15.
REQ-049 Same fault, stop_on_err=1 -> done with dividend=9, divisor=2, busy=0; no strt pulse after the failing operation.
REQ-050 B never raises idle, TIMEOUT=8 -> timeout_flag=1; each operation leaves WAIT 8 cycles after entry.
REQ-051 Both dividers return not_valid=0 for divisor 0 -> error counted at the first operation, fail_dividend=0, fail_divisor=0.
REQ-052 abort pulsed mid-sweep -> FINISH next cycle with pass=0; rst low mid-sweep -> all outputs 0 at once; a later go restarts at 0/0.

Source files
------------

// File: rtl/divider_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : divider_pkg
//  Description : Shared definitions for the divider cross-check sweeper.
//                Holds the sweeper FSM state encoding and the default
//                parameter values used by the top level.
//  Revision    : 1.0  initial release
// ============================================================================
package divider_pkg;

    // Default parameter values for divider_sweeper
    localparam int c_def_width   = 8;
    localparam int c_def_timeout = 64;
    localparam int c_def_err_w   = 16;

    // Sweeper FSM state encoding
    localparam int             c_st_w      = 3;
    localparam logic [c_st_w-1:0] c_st_idle   = 3'd0;
    localparam logic [c_st_w-1:0] c_st_launch = 3'd1;
    localparam logic [c_st_w-1:0] c_st_settle = 3'd2;
    localparam logic [c_st_w-1:0] c_st_wait   = 3'd3;
    localparam logic [c_st_w-1:0] c_st_check  = 3'd4;
    localparam logic [c_st_w-1:0] c_st_next   = 3'd5;
    localparam logic [c_st_w-1:0] c_st_finish = 3'd6;

endpackage : divider_pkg
`default_nettype wire

// File: rtl/sweep_counter.sv
`default_nettype none
// ============================================================================
//  Module      : sweep_counter
//  Description : Operand pair generator for the divider sweep. The divisor
//                is the inner loop; the dividend advances when the divisor
//                wraps. Flags the final {all-ones, all-ones} pair.
//  Ports       : clk      - clock, rising edge
//                rst      - asynchronous reset, active-low
//                clr      - synchronous clear of both operands
//                inc      - advance to the next operand pair
//                dividend - current dividend
//                divisor  - current divisor
//                last     - current pair is the final one
//  Revision    : 1.0  initial release
// ============================================================================
module sweep_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] dividend,
    output logic [WIDTH-1:0] divisor,
    output logic             last
);

    logic [WIDTH-1:0] r_dividend;
    logic [WIDTH-1:0] r_divisor;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_dividend <= '0;
            r_divisor  <= '0;
        end else if (clr) begin
            r_dividend <= '0;
            r_divisor  <= '0;
        end else if (inc) begin
            r_divisor <= r_divisor + 1'b1;
            if (&r_divisor) begin
                r_dividend <= r_dividend + 1'b1;
            end
        end
    end

    assign dividend = r_dividend;
    assign divisor  = r_divisor;
    assign last     = (&r_dividend) & (&r_divisor);

endmodule : sweep_counter
`default_nettype wire

// File: rtl/divider_sweeper.sv
`default_nettype none
// ============================================================================
//  Module      : divider_sweeper
//  Description : Drives two dividers (A and B) with every operand pair of
//                the WIDTH x WIDTH space and cross-checks their results.
//                Counts mismatches, divide-by-zero contract violations and
//                busy timeouts; records the operands of the first failure.
//  Ports       : clk, rst            - clock / async active-low reset
//                go                  - start pulse (ignored while busy)
//                abort               - end the sweep in progress
//                stop_on_err         - halt at the first failing operation
//                strt                - start pulse to both dividers
//                dividend, divisor   - operands to both dividers
//                quotient_*, remainder_*, not_valid_*, idle_* - divider A/B
//                busy, done, pass    - sweep status
//                err_cnt             - saturating error count
//                timeout_flag        - at least one timeout seen
//                fail_dividend/divisor - operands of the first failure
//  Revision    : 1.0  initial release
// ============================================================================
module divider_sweeper
    import divider_pkg::*;
#(
    parameter int WIDTH   = c_def_width,
    parameter int TIMEOUT = c_def_timeout,
    parameter int ERR_W   = c_def_err_w
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             go,
    input  logic             abort,
    input  logic             stop_on_err,
    output logic             strt,
    output logic [WIDTH-1:0] dividend,
    output logic [WIDTH-1:0] divisor,
    input  logic [WIDTH-1:0] quotient_a,
    input  logic [WIDTH-1:0] remainder_a,
    input  logic [WIDTH-1:0] quotient_b,
    input  logic [WIDTH-1:0] remainder_b,
    input  logic             not_valid_a,
    input  logic             idle_a,
    input  logic             not_valid_b,
    input  logic             idle_b,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_cnt,
    output logic             timeout_flag,
    output logic [WIDTH-1:0] fail_dividend,
    output logic [WIDTH-1:0] fail_divisor
);

    localparam int               CNT_W       = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] c_wait_last = CNT_W'(TIMEOUT - 1);

    logic [c_st_w-1:0] r_state;
    logic [c_st_w-1:0] w_next_state;
    logic [CNT_W-1:0]  r_wait_cnt;
    logic              r_timed_out;
    logic [ERR_W-1:0]  r_err_cnt;
    logic              r_timeout_flag;
    logic [WIDTH-1:0]  r_fail_dividend;
    logic [WIDTH-1:0]  r_fail_divisor;
    logic              r_done;
    logic              r_pass;

    logic w_busy;
    logic w_abort;
    logic w_start;
    logic w_clr;
    logic w_inc;
    logic w_last;
    logic w_both_idle;
    logic w_timeout;
    logic w_cmp_err;
    logic w_check_err;
    logic w_op_err;
    logic w_new_err;
    logic w_to_finish;

    // ------------------------------------------------------------------
    // Operand pair counter
    // ------------------------------------------------------------------
    sweep_counter #(
        .WIDTH (WIDTH)
    ) u_sweep_counter (
        .clk      (clk),
        .rst      (rst),
        .clr      (w_clr),
        .inc      (w_inc),
        .dividend (dividend),
        .divisor  (divisor),
        .last     (w_last)
    );

    assign w_busy      = (r_state != c_st_idle) && (r_state != c_st_finish);
    assign w_abort     = abort && w_busy;
    assign w_start     = go && (r_state == c_st_idle);
    assign w_both_idle = idle_a && idle_b;

    // Timeout fires on the last allowed WAIT cycle unless both report idle.
    assign w_timeout = (r_state == c_st_wait) && !w_both_idle &&
                       (r_wait_cnt == c_wait_last);

    // Quotient/remainder only matter when at least one divider claims a
    // valid result; a zero divisor must be flagged not-valid by both.
    assign w_cmp_err = (not_valid_a != not_valid_b) ||
                       (!(not_valid_a && not_valid_b) &&
                        ((quotient_a != quotient_b) || (remainder_a != remainder_b))) ||
                       ((divisor == '0) && (!not_valid_a || !not_valid_b));

    // A timed-out operation is not compared, so at most one error is
    // counted per operation.
    assign w_check_err = (r_state == c_st_check) && !r_timed_out && w_cmp_err;
    assign w_op_err    = r_timed_out || w_check_err;
    assign w_new_err   = (w_timeout || w_check_err) && !w_abort;
    assign w_to_finish = (w_next_state == c_st_finish) && (r_state != c_st_finish);

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_clr        = 1'b0;
        w_inc        = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (go) begin
                    w_next_state = c_st_launch;
                    w_clr        = 1'b1;
                end
            end
            c_st_launch: w_next_state = c_st_settle;
            c_st_settle: w_next_state = c_st_wait;
            c_st_wait: begin
                if (w_both_idle || w_timeout) begin
                    w_next_state = c_st_check;
                end
            end
            c_st_check: begin
                if (stop_on_err && w_op_err) begin
                    w_next_state = c_st_finish;
                end else begin
                    w_next_state = c_st_next;
                end
            end
            c_st_next: begin
                if (w_last) begin
                    w_next_state = c_st_finish;
                end else begin
                    w_next_state = c_st_launch;
                    w_inc        = 1'b1;
                end
            end
            c_st_finish: w_next_state = c_st_idle;
            default:     w_next_state = c_st_idle;
        endcase
        // Abort overrides everything and freezes the operands.
        if (w_abort) begin
            w_next_state = c_st_finish;
            w_inc        = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // WAIT cycle counter and per-operation timeout marker
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wait_cnt  <= '0;
            r_timed_out <= 1'b0;
        end else begin
            if (r_state == c_st_settle) begin
                r_wait_cnt <= '0;
            end else if (r_state == c_st_wait) begin
                r_wait_cnt <= r_wait_cnt + 1'b1;
            end
            if (r_state == c_st_launch) begin
                r_timed_out <= 1'b0;
            end else if (w_timeout) begin
                r_timed_out <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Error bookkeeping and completion status
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_err_cnt       <= '0;
            r_timeout_flag  <= 1'b0;
            r_fail_dividend <= '0;
            r_fail_divisor  <= '0;
            r_done          <= 1'b0;
            r_pass          <= 1'b0;
        end else if (w_start) begin
            r_err_cnt       <= '0;
            r_timeout_flag  <= 1'b0;
            r_fail_dividend <= '0;
            r_fail_divisor  <= '0;
            r_done          <= 1'b0;
            r_pass          <= 1'b0;
        end else begin
            if (w_new_err) begin
                if (r_err_cnt == '0) begin
                    r_fail_dividend <= dividend;
                    r_fail_divisor  <= divisor;
                end
                if (r_err_cnt != {ERR_W{1'b1}}) begin
                    r_err_cnt <= r_err_cnt + 1'b1;
                end
            end
            if (w_timeout && !w_abort) begin
                r_timeout_flag <= 1'b1;
            end
            // Status is set on entry to FINISH so it is visible there;
            // the error landing in this same cycle is folded in.
            if (w_to_finish) begin
                r_done <= 1'b1;
                r_pass <= !w_abort && (r_err_cnt == '0) && !w_new_err;
            end
        end
    end

    assign strt          = (r_state == c_st_launch);
    assign busy          = w_busy;
    assign done          = r_done;
    assign pass          = r_pass;
    assign err_cnt       = r_err_cnt;
    assign timeout_flag  = r_timeout_flag;
    assign fail_dividend = r_fail_dividend;
    assign fail_divisor  = r_fail_divisor;

endmodule : divider_sweeper
`default_nettype wire
